// File: rtl/hicore_clint.sv
// Core-local interruptor: 64-bit mtime with prescaler, mtimecmp, MSIP, and a single-cycle-latency register bus.
// Every accepted request gets exactly one rvalid pulse on the following cycle; the bus never stalls.
module hicore_clint #(
    parameter int unsigned TICK_DIV   = 1,
    parameter logic [15:0] BASE_MATCH = 16'h0200
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        bus_req,
    input  logic        bus_we,
    input  logic [31:0] bus_addr,
    input  logic [31:0] bus_wdata,
    output logic        bus_ready,
    output logic        bus_rvalid,
    output logic [31:0] bus_rdata,
    output logic        m_time_irq,
    output logic        m_soft_irq
);

    typedef enum logic {IDLE, RESP} state_t;

    localparam logic [15:0] TICK_MAX     = 16'(TICK_DIV - 1);
    localparam logic [15:0] OFF_MSIP     = 16'h0000;
    localparam logic [15:0] OFF_CMP_LO   = 16'h4000;
    localparam logic [15:0] OFF_CMP_HI   = 16'h4004;
    localparam logic [15:0] OFF_MTIME_LO = 16'hBFF8;
    localparam logic [15:0] OFF_MTIME_HI = 16'hBFFC;

    state_t      state_q,    state_d;
    logic [31:0] rdata_q,    rdata_d;
    logic [15:0] presc_q,    presc_d;
    logic [63:0] mtime_q,    mtime_d;
    logic [31:0] shadow_q,   shadow_d;
    logic [63:0] mtimecmp_q, mtimecmp_d;
    logic        msip_q,     msip_d;
    logic        time_irq_q, time_irq_d;

    logic        sel;
    logic        rd_en;
    logic        wr_en;
    logic        tick;
    logic [15:0] off;

    always_comb begin
        sel        = (bus_addr[31:16] == BASE_MATCH);
        rd_en      = bus_req && !bus_we && sel;
        wr_en      = bus_req && bus_we && sel;
        off        = bus_addr[15:0];
        tick       = (presc_q == TICK_MAX);

        state_d    = state_q;
        rdata_d    = '0;
        presc_d    = tick ? 16'd0 : presc_q + 16'd1;
        mtime_d    = tick ? mtime_q + 64'd1 : mtime_q;
        shadow_d   = shadow_q;
        mtimecmp_d = mtimecmp_q;
        msip_d     = msip_q;
        time_irq_d = (mtime_q >= mtimecmp_q);

        case (state_q)
            IDLE:    state_d = bus_req ? RESP : IDLE;
            RESP:    state_d = bus_req ? RESP : IDLE;
            default: state_d = IDLE;
        endcase

        if (rd_en) begin
            case (off)
                OFF_MSIP:     rdata_d = {31'd0, msip_q};
                OFF_CMP_LO:   rdata_d = mtimecmp_q[31:0];
                OFF_CMP_HI:   rdata_d = mtimecmp_q[63:32];
                OFF_MTIME_LO: begin
                    rdata_d  = mtime_q[31:0];
                    shadow_d = mtime_q[63:32];
                end
                OFF_MTIME_HI: rdata_d = shadow_q;
                default:      rdata_d = '0;
            endcase
        end

        // A software write to either mtime half wins over the tick: the other
        // half keeps its pre-write value with no carry, and the prescaler restarts.
        if (wr_en) begin
            case (off)
                OFF_MSIP:     msip_d = bus_wdata[0];
                OFF_CMP_LO:   mtimecmp_d[31:0]  = bus_wdata;
                OFF_CMP_HI:   mtimecmp_d[63:32] = bus_wdata;
                OFF_MTIME_LO: begin
                    mtime_d = {mtime_q[63:32], bus_wdata};
                    presc_d = 16'd0;
                end
                OFF_MTIME_HI: begin
                    mtime_d = {bus_wdata, mtime_q[31:0]};
                    presc_d = 16'd0;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            rdata_q    <= '0;
            presc_q    <= '0;
            mtime_q    <= '0;
            shadow_q   <= '0;
            mtimecmp_q <= '1;
            msip_q     <= 1'b0;
            time_irq_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            rdata_q    <= rdata_d;
            presc_q    <= presc_d;
            mtime_q    <= mtime_d;
            shadow_q   <= shadow_d;
            mtimecmp_q <= mtimecmp_d;
            msip_q     <= msip_d;
            time_irq_q <= time_irq_d;
        end
    end

    assign bus_ready  = 1'b1;
    assign bus_rvalid = (state_q == RESP);
    assign bus_rdata  = rdata_q;
    assign m_time_irq = time_irq_q;
    assign m_soft_irq = msip_q;

endmodule

// File: tb/tb_hicore_clint.sv
// Bench for hicore_clint: a TICK_DIV=1 instance checked every cycle against a register-map model,
// plus a TICK_DIV=4 instance for prescaler timing, with hand-computed literal checks.
module tb_hicore_clint;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req, req4, we;
    logic [31:0] addr, wdata;

    logic        ready1, rvalid1, tirq1, sirq1;
    logic [31:0] rdata1;
    logic        ready4, rvalid4, tirq4, sirq4;
    logic [31:0] rdata4;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    hicore_clint #(.TICK_DIV(1), .BASE_MATCH(16'h0200)) dut1 (
        .clk(clk), .rst_n(rst_n), .bus_req(req), .bus_we(we), .bus_addr(addr),
        .bus_wdata(wdata), .bus_ready(ready1), .bus_rvalid(rvalid1), .bus_rdata(rdata1),
        .m_time_irq(tirq1), .m_soft_irq(sirq1));

    hicore_clint #(.TICK_DIV(4), .BASE_MATCH(16'h0200)) dut4 (
        .clk(clk), .rst_n(rst_n), .bus_req(req4), .bus_we(we), .bus_addr(addr),
        .bus_wdata(wdata), .bus_ready(ready4), .bus_rvalid(rvalid4), .bus_rdata(rdata4),
        .m_time_irq(tirq4), .m_soft_irq(sirq4));

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Register-map model of the TICK_DIV=1 instance: one mtime step per clock.
    logic [63:0] m_mtime, m_cmp, t_now;
    logic [31:0] m_shadow, m_rdata;
    logic        m_msip, m_irq, m_rvalid;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_mtime = 64'd0; m_cmp = '1; m_shadow = 32'd0; m_msip = 1'b0;
            m_irq = 1'b0; m_rvalid = 1'b0; m_rdata = 32'd0;
        end else begin
            t_now    = m_mtime;
            m_irq    = (t_now >= m_cmp);
            m_rvalid = req;
            m_rdata  = 32'd0;
            m_mtime  = t_now + 64'd1;
            if (req && addr[31:16] == 16'h0200) begin
                if (!we) begin
                    case (addr[15:0])
                        16'h0000: m_rdata = {31'd0, m_msip};
                        16'h4000: m_rdata = m_cmp[31:0];
                        16'h4004: m_rdata = m_cmp[63:32];
                        16'hBFF8: begin m_rdata = t_now[31:0]; m_shadow = t_now[63:32]; end
                        16'hBFFC: m_rdata = m_shadow;
                        default:  m_rdata = 32'd0;
                    endcase
                end else begin
                    case (addr[15:0])
                        16'h0000: m_msip = wdata[0];
                        16'h4000: m_cmp[31:0] = wdata;
                        16'h4004: m_cmp[63:32] = wdata;
                        16'hBFF8: m_mtime = {t_now[63:32], wdata};
                        16'hBFFC: m_mtime = {wdata, t_now[31:0]};
                        default: ;
                    endcase
                end
            end
        end
    end

    always @(posedge clk) begin
        #1;
        chk("rvalid", {63'd0, rvalid1}, {63'd0, m_rvalid});
        chk("rdata", {32'd0, rdata1}, {32'd0, m_rdata});
        chk("time_irq", {63'd0, tirq1}, {63'd0, m_irq});
        chk("soft_irq", {63'd0, sirq1}, {63'd0, m_msip});
        chk("ready", {63'd0, ready1}, 64'd1);
        chk("div4_time_irq", {63'd0, tirq4}, 64'd0);
    end

    logic [31:0] r;
    logic        rv;

    task automatic acc(input logic w, input logic [31:0] a, input logic [31:0] d);
        @(negedge clk);
        req = 1'b1; we = w; addr = a; wdata = d;
        @(posedge clk);
        #1;
        r  = rdata1;
        rv = rvalid1;
    endtask

    task automatic idle();
        @(negedge clk);
        req = 1'b0; we = 1'b0;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0; req = 1'b0; req4 = 1'b0; we = 1'b0; addr = '0; wdata = '0;
        repeat (3) @(negedge clk);
        chk("reset_rvalid", {63'd0, rvalid1}, 64'd0);
        chk("reset_rdata", {32'd0, rdata1}, 64'd0);
        chk("reset_tirq", {63'd0, tirq1}, 64'd0);
        chk("reset_sirq", {63'd0, sirq1}, 64'd0);
        rst_n = 1'b1;

        // 40 idle cycles: TICK_DIV=4 gives mtime=10, TICK_DIV=1 gives 40.
        repeat (40) @(negedge clk);
        req = 1'b1; req4 = 1'b1; we = 1'b0; addr = 32'h0200_BFF8;
        @(posedge clk);
        #1;
        chk("div4_mtime_after_40", {32'd0, rdata4}, 64'd10);
        chk("div4_rvalid", {63'd0, rvalid4}, 64'd1);
        chk("div1_mtime_after_40", {32'd0, rdata1}, 64'd40);
        @(negedge clk);
        req = 1'b0; req4 = 1'b0;

        // Software interrupt
        acc(1'b1, 32'h0200_0000, 32'hFFFF_FFFF);
        chk("msip_irq_set", {63'd0, sirq1}, 64'd1);
        acc(1'b0, 32'h0200_0000, 32'd0);
        chk("msip_read", {32'd0, r}, 64'd1);
        acc(1'b1, 32'h0200_0000, 32'd0);
        chk("msip_irq_clr", {63'd0, sirq1}, 64'd0);

        // Timer compare: mtime=k after the k-th edge following the LO write.
        acc(1'b1, 32'h0200_BFF8, 32'd0);
        acc(1'b1, 32'h0200_4004, 32'd0);
        acc(1'b1, 32'h0200_4000, 32'h20);
        for (int k = 3; k <= 33; k++) begin
            idle();
            if (k == 32) chk("tirq_before_match", {63'd0, tirq1}, 64'd0);
            if (k == 33) chk("tirq_after_match", {63'd0, tirq1}, 64'd1);
        end
        acc(1'b1, 32'h0200_4000, 32'hFFFF_FFFF);
        chk("tirq_on_cmp_write", {63'd0, tirq1}, 64'd1);
        idle();
        chk("tirq_cleared", {63'd0, tirq1}, 64'd0);

        // 64-bit wrap and shadow coherence
        acc(1'b1, 32'h0200_BFFC, 32'hFFFF_FFFF);
        acc(1'b1, 32'h0200_BFF8, 32'hFFFF_FFFE);
        idle();
        acc(1'b0, 32'h0200_BFF8, 32'd0);
        chk("wrap_lo_pre", {32'd0, r}, 64'hFFFF_FFFF);
        acc(1'b0, 32'h0200_BFFC, 32'd0);
        chk("wrap_hi_shadow", {32'd0, r}, 64'hFFFF_FFFF);
        acc(1'b0, 32'h0200_BFF8, 32'd0);
        chk("wrap_lo_post", {32'd0, r}, 64'd1);
        acc(1'b0, 32'h0200_BFFC, 32'd0);
        chk("wrap_hi_post", {32'd0, r}, 64'd0);

        // Out-of-range writes ignored, four back-to-back reads
        acc(1'b1, 32'h0200_0000, 32'd1);
        acc(1'b1, 32'h0200_1234, 32'hDEAD_BEEF);
        acc(1'b1, 32'h0300_4000, 32'h55);
        acc(1'b0, 32'h0200_0000, 32'd0);
        chk("b2b0_vld", {63'd0, rv}, 64'd1);
        chk("b2b0_msip", {32'd0, r}, 64'd1);
        acc(1'b0, 32'h0200_4000, 32'd0);
        chk("b2b1_vld", {63'd0, rv}, 64'd1);
        chk("b2b1_cmp_lo", {32'd0, r}, 64'hFFFF_FFFF);
        acc(1'b0, 32'h0200_1234, 32'd0);
        chk("b2b2_vld", {63'd0, rv}, 64'd1);
        chk("b2b2_unmapped", {32'd0, r}, 64'd0);
        acc(1'b0, 32'h0300_0000, 32'd0);
        chk("b2b3_vld", {63'd0, rv}, 64'd1);
        chk("b2b3_badbase", {32'd0, r}, 64'd0);
        idle();
        chk("b2b_end_vld", {63'd0, rvalid1}, 64'd0);

        // Reset while a response is outstanding
        acc(1'b1, 32'h0200_4000, 32'd0);
        acc(1'b0, 32'h0200_BFF8, 32'd0);
        chk("pre_reset_vld", {63'd0, rv}, 64'd1);
        chk("pre_reset_tirq", {63'd0, tirq1}, 64'd1);
        @(negedge clk);
        rst_n = 1'b0; req = 1'b0; we = 1'b0;
        #1;
        chk("rst_rvalid", {63'd0, rvalid1}, 64'd0);
        chk("rst_rdata", {32'd0, rdata1}, 64'd0);
        chk("rst_tirq", {63'd0, tirq1}, 64'd0);
        chk("rst_sirq", {63'd0, sirq1}, 64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            idle();
            chk("post_reset_no_vld", {63'd0, rvalid1}, 64'd0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
